// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller shared by an instruction-fetch port and a load/store port.
// Optional MEMCTRL_IO_STALL_EN: stores with addr[17:16]==2'b11 wait in LS_WRITE while io_buffer_full is high.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_rollback,
    input  logic        in_if_ena,
    input  logic [31:0] in_if_addr,
    output logic        out_if_ready,
    output logic [31:0] out_if_inst,
    input  logic        in_ls_ena,
    input  logic        in_ls_write,
    input  logic [31:0] in_ls_addr,
    input  logic [1:0]  in_ls_size,
    input  logic [31:0] in_ls_data,
    output logic        out_ls_ready,
    output logic [31:0] out_ls_data,
    input  logic [7:0]  in_ram_din,
    output logic [7:0]  out_ram_dout,
    output logic [31:0] out_ram_addr,
    output logic        out_ram_wr,
    input  logic        io_buffer_full,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a one-cycle *_ena pulse is a request; it is captured into a pending slot and
    // answered by exactly one one-cycle *_ready pulse, unless rolled back (reads only) or reset.
    typedef enum logic [1:0] {IDLE = 2'd0, IF_READ = 2'd1, LS_READ = 2'd2, LS_WRITE = 2'd3} state_e;

    state_e      state_q;
    logic [2:0]  k_q, n_q;
    logic [1:0]  cap_q;
    logic [31:0] base_q, wdata_q, rdata_q, rdata_m;
    logic        if_pend_q, if_pend_d, ls_pend_q, ls_pend_d;
    logic [31:0] if_addr_q, ls_addr_q, ls_data_q;
    logic [1:0]  ls_size_q;
    logic        ls_write_q;
    logic        if_take, ls_take, is_read, ls_start, if_start;
    logic [31:0] if_addr_e, ls_addr_e, ls_data_e;
    logic [1:0]  ls_size_e;
    logic        ls_write_e;
    logic        stall_entry, stall_write;
    logic [7:0]  wbyte;

    // Reads arriving with a rollback belong to the squashed path; stores are architectural.
    assign if_take    = in_if_ena & ~in_rollback;
    assign ls_take    = in_ls_ena & (in_ls_write | ~in_rollback);
    assign is_read    = (state_q == IF_READ) || (state_q == LS_READ);
    assign ls_start   = (state_q == IDLE) && (ls_pend_q || ls_take);
    assign if_start   = (state_q == IDLE) && !(ls_pend_q || ls_take) && (if_pend_q || if_take);
    assign if_addr_e  = if_pend_q ? if_addr_q  : in_if_addr;
    assign ls_addr_e  = ls_pend_q ? ls_addr_q  : in_ls_addr;
    assign ls_data_e  = ls_pend_q ? ls_data_q  : in_ls_data;
    assign ls_size_e  = ls_pend_q ? ls_size_q  : in_ls_size;
    assign ls_write_e = ls_pend_q ? ls_write_q : in_ls_write;
    assign wbyte      = wdata_q[{k_q[1:0], 3'b000} +: 8];
    assign dbg_state_o = state_q;

`ifdef MEMCTRL_IO_STALL_EN
    assign stall_entry = (ls_addr_e[17:16] == 2'b11) && io_buffer_full;
    assign stall_write = (base_q[17:16] == 2'b11) && io_buffer_full;
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign stall_entry = 1'b0;
    assign stall_write = 1'b0;
`endif

    always_comb begin
        rdata_m = rdata_q;
        rdata_m[{cap_q, 3'b000} +: 8] = in_ram_din;
    end

    // An older pending request is served first; a pulse in the same cycle takes its slot.
    always_comb begin
        if_pend_d = if_pend_q;
        if (is_read && in_rollback) if_pend_d = 1'b0;
        if (if_take) if_pend_d = 1'b1;
        if (if_start) if_pend_d = if_pend_q & if_take;
        ls_pend_d = ls_pend_q;
        if (is_read && in_rollback && !ls_write_q) ls_pend_d = 1'b0;
        if (ls_take) ls_pend_d = 1'b1;
        if (ls_start) ls_pend_d = ls_pend_q & ls_take;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_pend_q  <= 1'b0;
            ls_pend_q  <= 1'b0;
            if_addr_q  <= '0;
            ls_addr_q  <= '0;
            ls_data_q  <= '0;
            ls_size_q  <= '0;
            ls_write_q <= 1'b0;
        end else begin
            if_pend_q <= if_pend_d;
            ls_pend_q <= ls_pend_d;
            if (if_take) if_addr_q <= in_if_addr;
            if (ls_take) begin
                ls_addr_q  <= in_ls_addr;
                ls_data_q  <= in_ls_data;
                ls_size_q  <= in_ls_size;
                ls_write_q <= in_ls_write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            n_q          <= '0;
            cap_q        <= '0;
            base_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            out_ram_wr   <= 1'b0;
            out_ram_addr <= '0;
            out_ram_dout <= '0;
            out_if_ready <= 1'b0;
            out_ls_ready <= 1'b0;
            out_if_inst  <= '0;
            out_ls_data  <= '0;
        end else begin
            out_if_ready <= 1'b0;
            out_ls_ready <= 1'b0;
            case (state_q)
                IDLE: begin
                    out_ram_wr   <= 1'b0;
                    out_ram_addr <= '0;
                    cap_q        <= '0;
                    rdata_q      <= '0;
                    if (ls_start) begin
                        base_q  <= ls_addr_e;
                        n_q     <= {1'b0, ls_size_e} + 3'd1;
                        wdata_q <= ls_data_e;
                        if (ls_write_e) begin
                            state_q <= LS_WRITE;
                            if (stall_entry) begin
                                k_q <= 3'd0;
                            end else begin
                                out_ram_wr   <= 1'b1;
                                out_ram_addr <= ls_addr_e;
                                out_ram_dout <= ls_data_e[7:0];
                                k_q          <= 3'd1;
                            end
                        end else begin
                            state_q      <= LS_READ;
                            out_ram_addr <= ls_addr_e;
                            k_q          <= 3'd1;
                        end
                    end else if (if_start) begin
                        state_q      <= IF_READ;
                        base_q       <= if_addr_e;
                        n_q          <= 3'd4;
                        out_ram_addr <= if_addr_e;
                        k_q          <= 3'd1;
                    end
                end
                IF_READ, LS_READ: begin
                    if (in_rollback) begin
                        state_q      <= IDLE;
                        out_ram_addr <= '0;
                    end else begin
                        // k counts cycles since the first address; byte k-2 is on the bus now.
                        out_ram_addr <= (k_q < n_q) ? base_q + {29'd0, k_q} : 32'd0;
                        if (k_q >= 3'd2) begin
                            rdata_q <= rdata_m;
                            cap_q   <= cap_q + 2'd1;
                        end
                        if (k_q == n_q + 3'd1) begin
                            state_q <= IDLE;
                            if (state_q == IF_READ) begin
                                out_if_ready <= 1'b1;
                                out_if_inst  <= rdata_m;
                            end else begin
                                out_ls_ready <= 1'b1;
                                out_ls_data  <= rdata_m;
                            end
                        end else begin
                            k_q <= k_q + 3'd1;
                        end
                    end
                end
                LS_WRITE: begin
                    if (k_q < n_q) begin
                        if (stall_write) begin
                            out_ram_wr <= 1'b0;
                        end else begin
                            out_ram_wr   <= 1'b1;
                            out_ram_addr <= base_q + {29'd0, k_q};
                            out_ram_dout <= wbyte;
                            k_q          <= k_q + 3'd1;
                        end
                    end else begin
                        out_ram_wr   <= 1'b0;
                        out_ram_addr <= '0;
                        out_ls_ready <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: RAM responder, reference memory, scoreboard of ready events.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst, in_rollback, in_if_ena, in_ls_ena, in_ls_write, io_buffer_full;
  logic [31:0] in_if_addr, in_ls_addr, in_ls_data;
  logic [1:0] in_ls_size;
  logic [7:0] in_ram_din;
  logic out_if_ready, out_ls_ready, out_ram_wr;
  logic [31:0] out_if_inst, out_ls_data, out_ram_addr;
  logic [7:0] out_ram_dout;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .in_rollback(in_rollback),
    .in_if_ena(in_if_ena), .in_if_addr(in_if_addr),
    .out_if_ready(out_if_ready), .out_if_inst(out_if_inst),
    .in_ls_ena(in_ls_ena), .in_ls_write(in_ls_write), .in_ls_addr(in_ls_addr),
    .in_ls_size(in_ls_size), .in_ls_data(in_ls_data),
    .out_ls_ready(out_ls_ready), .out_ls_data(out_ls_data),
    .in_ram_din(in_ram_din), .out_ram_dout(out_ram_dout), .out_ram_addr(out_ram_addr),
    .out_ram_wr(out_ram_wr), .io_buffer_full(io_buffer_full), .dbg_state_o(dbg_state)
  );

  int total = 0, bad = 0;
  int if_cnt = 0, ls_cnt = 0, wr_cnt = 0, c_if, c_ls, c_wr;
  logic [33:0] exp_q[$];  // {is_store, is_ls_port, data}
  logic [7:0] ram [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];
  logic [31:0] word, ra;
  logic [1:0] rs;
  logic [1:0] sz_tab [3] = '{2'd0, 2'd1, 2'd3};

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return dflt(a);
  endfunction
  function automatic logic [7:0] shad_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return dflt(a);
  endfunction
  function automatic logic [31:0] shad_word(input logic [31:0] a, input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[8*i +: 8] = shad_rd(a + 32'(i));
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RAM responder: one-cycle read latency, writes on the clock edge.
  always @(posedge clk) begin
    if (out_ram_wr === 1'b1) begin
      ram[out_ram_addr] = out_ram_dout;
      wr_cnt++;
    end
    in_ram_din <= ram_rd(out_ram_addr);
  end

  task automatic pop_check(input logic is_ls);
    logic [33:0] e;
    check_eq("ready_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("ready_port", {31'd0, is_ls}, {31'd0, e[32]});
      if (!e[33]) check_eq(is_ls ? "ls_data" : "if_inst", is_ls ? out_ls_data : out_if_inst, e[31:0]);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (out_if_ready === 1'b1) begin if_cnt++; pop_check(1'b0); end
      if (out_ls_ready === 1'b1) begin ls_cnt++; pop_check(1'b1); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    shadow[a] = b;
  endtask

  task automatic set_if(input logic [31:0] a, input bit push);
    in_if_ena = 1'b1;
    in_if_addr = a;
    if (push) exp_q.push_back({2'b00, shad_word(a, 4)});
  endtask

  task automatic set_ls(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] d, input bit push);
    in_ls_ena = 1'b1; in_ls_write = wr; in_ls_addr = a; in_ls_size = sz; in_ls_data = d;
    if (push) begin
      if (wr) begin
        for (int i = 0; i <= int'(sz); i++) shadow[a + 32'(i)] = d[8*i +: 8];
        exp_q.push_back({2'b11, 32'd0});
      end else begin
        exp_q.push_back({2'b01, shad_word(a, int'(sz) + 1)});
      end
    end
  endtask

  task automatic clear_reqs();
    in_if_ena = 1'b0;
    in_ls_ena = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic simple_ls(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    tick(); set_ls(wr, a, sz, d, 1'b1); tick(); clear_reqs();
    drain(12);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: summary not reached, got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_rollback = 1'b0; in_if_ena = 1'b0; in_ls_ena = 1'b0; in_ls_write = 1'b0;
    io_buffer_full = 1'b0; in_if_addr = '0; in_ls_addr = '0; in_ls_data = '0; in_ls_size = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_wr", out_ram_wr, 0);
    check_eq("rst_addr", out_ram_addr, 0);
    check_eq("rst_dout", out_ram_dout, 0);
    check_eq("rst_if_ready", out_if_ready, 0);
    check_eq("rst_ls_ready", out_ls_ready, 0);
    check_eq("rst_if_inst", out_if_inst, 0);
    check_eq("rst_ls_data", out_ls_data, 0);
    check_eq("rst_state", dbg_state, 0);
    tick(); rst = 1'b0;

    // Fetch of 0x00000513 from 0x1000
    preset(32'h1000, 8'h13); preset(32'h1001, 8'h05); preset(32'h1002, 8'h00); preset(32'h1003, 8'h00);
    tick(); set_if(32'h1000, 1'b1); tick(); clear_reqs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("fetch_addr", out_ram_addr, 32'h1000 + 32'(k));
      check_eq("fetch_wr", out_ram_wr, 0);
    end
    @(negedge clk); check_eq("fetch_ready_early", out_if_ready, 0);
    @(negedge clk); check_eq("fetch_ready", out_if_ready, 1);
    check_eq("fetch_inst", out_if_inst, 32'h00000513);
    drain(4);

    // Word store
    word = 32'hDEADBEEF;
    tick(); set_ls(1'b1, 32'h20, 2'd3, word, 1'b1); tick(); clear_reqs();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("st_wr", out_ram_wr, 1);
      check_eq("st_addr", out_ram_addr, 32'h20 + 32'(k));
      check_eq("st_dout", out_ram_dout, {24'd0, word[8*k +: 8]});
    end
    @(negedge clk); check_eq("st_ready", out_ls_ready, 1); check_eq("st_wr_off", out_ram_wr, 0);
    drain(4);

    // Loads of each size, byte load timing
    simple_ls(1'b0, 32'h20, 2'd3, 0);
    simple_ls(1'b0, 32'h22, 2'd1, 0);
    tick(); set_ls(1'b0, 32'h21, 2'd0, 0, 1'b1); tick(); clear_reqs();
    @(negedge clk); @(negedge clk); check_eq("ldb_ready_early", out_ls_ready, 0);
    @(negedge clk); check_eq("ldb_ready", out_ls_ready, 1); check_eq("ldb_data", out_ls_data, 32'h000000BE);
    drain(4);

    // Same-cycle fetch and load: load first, fetch starts in the load's ready cycle
    c_if = if_cnt; c_ls = ls_cnt;
    tick(); set_ls(1'b0, 32'h20, 2'd3, 0, 1'b1); set_if(32'h1000, 1'b1); tick(); clear_reqs();
    @(negedge clk); check_eq("arb_ls_first", out_ram_addr, 32'h20);
    repeat (5) @(negedge clk); check_eq("arb_ls_ready", out_ls_ready, 1);
    @(negedge clk); check_eq("arb_if_addr", out_ram_addr, 32'h1000);
    drain(12);
    check_eq("arb_if_count", if_cnt - c_if, 1);
    check_eq("arb_ls_count", ls_cnt - c_ls, 1);

    // Rollback at T+3 of a fetch, with a store pulsed during the rollback
    c_if = if_cnt;
    tick(); set_if(32'h1000, 1'b0); tick(); clear_reqs();
    tick();
    tick(); in_rollback = 1'b1; set_ls(1'b1, 32'h40, 2'd0, 32'h000000A5, 1'b1);
    tick(); in_rollback = 1'b0; clear_reqs();
    @(negedge clk); check_eq("rb_idle", dbg_state, 0); check_eq("rb_no_ready", out_if_ready, 0);
    @(negedge clk); check_eq("rb_st_wr", out_ram_wr, 1); check_eq("rb_st_addr", out_ram_addr, 32'h40);
    check_eq("rb_st_dout", out_ram_dout, 32'hA5);
    drain(6);
    check_eq("rb_if_count", if_cnt - c_if, 0);

    // Load pulsed with rollback is dropped
    c_ls = ls_cnt;
    tick(); in_rollback = 1'b1; set_ls(1'b0, 32'h20, 2'd3, 0, 1'b0); tick(); in_rollback = 1'b0; clear_reqs();
    repeat (8) @(negedge clk);
    check_eq("drop_idle", dbg_state, 0);
    check_eq("drop_count", ls_cnt - c_ls, 0);

    // Rollback during a store does not abort it
    tick(); set_ls(1'b1, 32'h60, 2'd3, 32'h11223344, 1'b1); tick(); clear_reqs();
    tick(); in_rollback = 1'b1; tick(); in_rollback = 1'b0;
    drain(8);
    simple_ls(1'b0, 32'h60, 2'd3, 0);

    // Reset at T+2 of a word store
    c_ls = ls_cnt;
    tick(); set_ls(1'b1, 32'h50, 2'd3, 32'hCAFEF00D, 1'b0); tick(); clear_reqs();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    c_wr = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("rstx_wr", out_ram_wr, 0);
      check_eq("rstx_ready", out_ls_ready, 0);
    end
    check_eq("rstx_wr_count", wr_cnt - c_wr, 0);
    check_eq("rstx_ls_count", ls_cnt - c_ls, 0);
    check_eq("rstx_byte2", ram_rd(32'h52), dflt(32'h52));
    shadow[32'h50] = 8'h0D; shadow[32'h51] = 8'hF0;
    simple_ls(1'b0, 32'h50, 2'd1, 0);

    // Address wrap
    preset(32'hFFFFFFFF, 8'h77); preset(32'h0, 8'h88);
    tick(); set_ls(1'b0, 32'hFFFFFFFF, 2'd1, 0, 1'b1); tick(); clear_reqs();
    @(negedge clk); check_eq("wrap_addr0", out_ram_addr, 32'hFFFFFFFF);
    @(negedge clk); check_eq("wrap_addr1", out_ram_addr, 32'h0);
    drain(6);

    // Store into the IO window with io_buffer_full high
    tick(); io_buffer_full = 1'b1; set_ls(1'b1, 32'h30000, 2'd0, 32'h3C, 1'b1); tick(); clear_reqs();
    @(negedge clk);
`ifdef MEMCTRL_IO_STALL_EN
    check_eq("io_stall_wr", out_ram_wr, 0);
    repeat (4) tick();
    io_buffer_full = 1'b0;
`else
    check_eq("io_ignored_wr", out_ram_wr, 1);
`endif
    drain(12);
    io_buffer_full = 1'b0;

    // Random mix of loads, stores and fetches
    for (int i = 0; i < 30; i++) begin
      ra = 32'h100 + 32'($urandom_range(0, 31));
      rs = sz_tab[$urandom_range(0, 2)];
      tick();
      if ($urandom_range(0, 3) == 0) set_if(ra, 1'b1);
      else set_ls(1'($urandom_range(0, 1)), ra, rs, $urandom, 1'b1);
      tick(); clear_reqs();
      drain(12);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: in_rollback  in  1  branch-mispredict flush.
REQ-003 SHALL have: in_if_ena  in  1  one-cycle fetch request pulse; in_if_addr  in  32  fetch address.
REQ-004 SHALL have: out_if_ready  out  1  one-cycle fetch-done pulse; out_if_inst  out  32  fetched word.
REQ-005 SHALL have: in_ls_ena  in  1  one-cycle load/store request pulse; in_ls_write  in  1  1=store; in_ls_addr  in  32; in_ls_size  in  2  byte count minus 1 (0,1,3 legal); in_ls_data  in  32  store data.
REQ-006 SHALL have: out_ls_ready  out  1  one-cycle done pulse; out_ls_data  out  32  load data, zero-extended.
REQ-007 SHALL have: in_ram_din  in  8; out_ram_dout  out  8; out_ram_addr  out  32; out_ram_wr  out  1  1=write; io_buffer_full  in  1.

Function
REQ-008 SHALL implement states IDLE, IF_READ, LS_READ, LS_WRITE, with a stage counter k and a captured-byte counter.
REQ-009 SHALL latch each request pulse into a pending flag (if_pend, ls_pend) plus its address/size/data, in any state, so that no pulse is lost.
REQ-010 In IDLE with any request (pulse this cycle or pending), SHALL move to a busy state at the next edge; LS wins over IF when both are present, and IF stays pending.
REQ-011 All RAM outputs SHALL be registered; base address visible on out_ram_addr the cycle after the request cycle T.
REQ-012 Read of n bytes: cycles T+1..T+n drive out_ram_addr=base+k, out_ram_wr=0; byte k arrives on in_ram_din at T+k+2 and SHALL be stored in bits [8k+7:8k].
REQ-013 After the last byte is captured, SHALL assert the port's ready for exactly one cycle (T+n+2) with data valid that cycle; fetch is always n=4, so out_if_ready is at T+6.
REQ-014 Write of n bytes: cycles T+1..T+n drive out_ram_wr=1, out_ram_addr=base+k, out_ram_dout=in_ls_data[8k+7:8k]; out_ls_ready SHALL pulse at T+n+1.
REQ-015 Return to IDLE in the ready cycle; a pending request SHALL start in that same cycle, with its first address one cycle later.
REQ-016 In IDLE, out_ram_wr=0 and out_ram_addr=0; the ready outputs SHALL be low except during their pulse cycle.
REQ-017 in_rollback=1 during IF_READ or LS_READ: at the next edge go to IDLE, no ready pulse, and clear if_pend and any pending load.
REQ-018 in_rollback=1 SHALL NOT abort LS_WRITE or a pending store; those SHALL complete normally.
REQ-019 A read request pulse coincident with in_rollback SHALL be dropped; a store pulse coincident with it SHALL be kept.
REQ-020 Address arithmetic SHALL be 32-bit modulo; 0xFFFFFFFF+1 wraps to 0.

Reset
REQ-021 On rst, at the next edge: state=IDLE, pending flags=0, out_ram_wr=0, out_ram_addr=0, out_ram_dout=0, both ready=0, both data outputs=0.
REQ-022 rst mid-transfer SHALL abandon the transfer, with no ready pulse and no further RAM writes after the reset edge.

Configuration
REQ-023 With MEMCTRL_IO_STALL_EN defined: a store with in_ls_addr[17:16]==2'b11 SHALL hold in LS_WRITE with out_ram_wr=0 and k frozen while io_buffer_full=1, then resume.
REQ-024 Without MEMCTRL_IO_STALL_EN: io_buffer_full SHALL be ignored, and the port still exists.

Verification
REQ-025 Fetch: in_if_ena at T, addr 0x1000, RAM bytes 13,05,00,00 -> out_ram_addr 0x1000..0x1003 at T+1..T+4; out_if_ready=1 at T+6 with out_if_inst=0x00000513.
REQ-026 Store word 0xDEADBEEF to 0x20 -> wr=1 at T+1..T+4 with dout EF,BE,AD,DE; out_ls_ready at T+5.
REQ-027 IF and load pulsed the same cycle -> load served first, then fetch starts in the load's ready cycle; exactly one ready on each port.
REQ-028 Rollback at T+3 of a fetch -> no out_if_ready and IDLE at T+4; a store issued during a rollback still completes.
REQ-029 MEMCTRL_IO_STALL_EN defined, store byte to 0x30000 while io_buffer_full=1 for 5 cycles -> no wr until it drops, then out_ls_ready 2 cycles later.
REQ-030 rst asserted at T+2 of a word store -> out_ram_wr=0 from T+3, no out_ls_ready.
